// File: rtl/imem_arbiter_if.sv
// Fetch, loader and instruction-memory signals shared by imem_arbiter and its environment.
interface imem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_stall;

  logic        ld_valid;
  logic        ld_we;
  logic        ld_last;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_ready;
  logic [31:0] ld_rdata;

  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        grant_ld;

  modport slave (
    input  if_req, if_addr, ld_valid, ld_we, ld_last, ld_addr, ld_wdata, mem_rdata,
    output if_rdata, if_stall, ld_ready, ld_rdata, mem_addr, mem_we, mem_wdata, grant_ld
  );

  modport master (
    output if_req, if_addr, ld_valid, ld_we, ld_last, ld_addr, ld_wdata, mem_rdata,
    input  if_rdata, if_stall, ld_ready, ld_rdata, mem_addr, mem_we, mem_wdata, grant_ld
  );
endinterface

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter between instruction fetch and a burst loader,
// with a bounded loader wait and a capped loader burst while fetch is requesting.
module imem_arbiter #(
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned WAIT_MAX  = 8
) (
  input logic           clk,
  input logic           rst,
  imem_arbiter_if.slave bus
);

  typedef enum logic {FETCH = 1'b0, LOAD = 1'b1} owner_e;

  localparam logic [3:0] WAIT_LAST  = 4'(WAIT_MAX - 1);
  localparam logic [3:0] WAIT_TOP   = 4'(WAIT_MAX);
  localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);

  owner_e     owner_q, owner_d;
  logic [3:0] wait_q, wait_d;
  logic [3:0] burst_q, burst_d;
  logic       is_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= FETCH;
      wait_q  <= '0;
      burst_q <= '0;
    end else begin
      owner_q <= owner_d;
      wait_q  <= wait_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    owner_d = owner_q;
    wait_d  = wait_q;
    burst_d = burst_q;
    unique case (owner_q)
      FETCH: begin
        if (bus.ld_valid && (!bus.if_req || wait_q == WAIT_LAST)) begin
          owner_d = LOAD;
          wait_d  = '0;
          burst_d = '0;
        end else if (bus.ld_valid) begin
          wait_d = (wait_q == WAIT_TOP) ? wait_q : wait_q + 4'd1;
        end else begin
          wait_d = '0;
        end
      end
      LOAD: begin
        wait_d = '0;
        if (bus.ld_valid) begin
          // Saturate so an uncapped burst (fetch idle) cannot wrap back under the cap.
          burst_d = (burst_q == '1) ? burst_q : burst_q + 4'd1;
          if (bus.ld_last || (bus.if_req && burst_q >= BURST_LAST)) begin
            owner_d = FETCH;
          end
        end else begin
          owner_d = FETCH;
        end
      end
      default: owner_d = FETCH;
    endcase
  end

  always_comb begin
    is_load       = (owner_q == LOAD);
    bus.grant_ld  = is_load;
    bus.mem_addr  = is_load ? bus.ld_addr : bus.if_addr;
    bus.mem_wdata = is_load ? bus.ld_wdata : '0;
    bus.mem_we    = !rst && is_load && bus.ld_valid && bus.ld_we;
    bus.if_stall  = !rst && is_load && bus.if_req;
    bus.ld_ready  = !rst && is_load && bus.ld_valid;
    bus.if_rdata  = bus.mem_rdata;
    bus.ld_rdata  = bus.mem_rdata;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter BURST_MAX, default 4: max consecutive loader transfers while fetch is requesting (legal 1..15).
REQ-002 SHALL have parameter WAIT_MAX, default 8: max cycles a pending loader request waits behind fetch (legal 1..15).
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have if_req  in  1  fetch wants a word this cycle.
REQ-005 SHALL have if_addr  in  32  fetch byte address.
REQ-006 SHALL have if_rdata  out  32  fetched word.
REQ-007 SHALL have if_stall  out  1  fetch not served this cycle; drives IF freeze.
REQ-008 SHALL have ld_valid  in  1; ld_we  in  1; ld_last  in  1; ld_addr  in  32; ld_wdata  in  32: loader request, write-enable, last-of-burst, address, write data.
REQ-009 SHALL have ld_ready  out  1  loader transfer accepted this cycle; ld_rdata  out  32  loader read data.
REQ-010 SHALL have mem_addr  out  32; mem_we  out  1; mem_wdata  out  32; mem_rdata  in  32: single-port instruction memory, combinational read, write on clk edge.
REQ-011 SHALL have grant_ld  out  1  registered owner flag (1 = loader owns memory).

Function
REQ-012 SHALL hold a 1-bit owner register, states FETCH and LOAD, updated only on rising clk.
REQ-013 SHALL route memory by owner: FETCH -> mem_addr=if_addr, mem_we=0, mem_wdata=0; LOAD -> mem_addr=ld_addr, mem_we=ld_valid&ld_we, mem_wdata=ld_wdata.
REQ-014 SHALL drive if_rdata=mem_rdata and ld_rdata=mem_rdata combinationally, both valid only in the cycle their side owns memory.
REQ-015 SHALL drive if_stall = if_req & (owner==LOAD) and ld_ready = ld_valid & (owner==LOAD), combinationally.
REQ-016 SHALL count a loader transfer as ld_valid & ld_ready in one cycle; loader holds valid, addr, data, we, last stable until ready.
REQ-017 SHALL keep wait_cnt (4 bits): in FETCH, increment (saturating at WAIT_MAX) each cycle ld_valid=1 and no switch occurs; clear on switch or when ld_valid=0.
REQ-018 SHALL, in FETCH, move to LOAD when ld_valid=1 and (if_req=0 or wait_cnt==WAIT_MAX-1); else stay FETCH.
REQ-019 SHALL keep burst_cnt (4 bits): clear on entry to LOAD; increment on each LOAD-state transfer.
REQ-020 SHALL, in LOAD with a transfer, stay LOAD iff ld_last=0 and (if_req=0 or burst_cnt<BURST_MAX-1); else return to FETCH.
REQ-021 SHALL, in LOAD with ld_valid=0 (abandoned burst), return to FETCH next cycle with no memory write.
REQ-022 SHALL give fetch priority on simultaneous first requests, except when WAIT_MAX is reached, where the loader wins.
REQ-023 SHALL make a FETCH-to-LOAD switch cost exactly one stalled fetch cycle per LOAD cycle; fetch is never stalled in FETCH.
REQ-024 SHALL drive grant_ld = owner register.

Reset
REQ-025 SHALL, on any rising clk with rst=1, set owner=FETCH, wait_cnt=0, burst_cnt=0, overriding all other next-state logic.
REQ-026 SHALL force mem_we=0, ld_ready=0, if_stall=0 combinationally while rst=1, including rst asserted mid-burst.
REQ-027 SHALL have after reset: grant_ld=0, if_stall=0, ld_ready=0, mem_we=0, mem_addr=if_addr.

Verification
REQ-028 SHALL cover idle loader: if_req=1, if_addr 0,4,8,... for 20 cycles, ld_valid=0 -> if_stall=0 every cycle, mem_addr tracks if_addr, grant_ld=0.
REQ-029 SHALL cover loader with fetch idle: if_req=0, ld_valid=1, ld_we=1, 3 words to 0x40/0x44/0x48, ld_last on third -> grant_ld=1 one cycle later, 3 consecutive ld_ready pulses and writes, then grant_ld=0.
REQ-030 SHALL cover starvation bound: if_req=1 constant, ld_valid raised at cycle t, WAIT_MAX=8 -> grant_ld=1 at t+8, if_stall=1 while grant_ld=1.
REQ-031 SHALL cover burst cap: if_req=1, 10-word loader burst, BURST_MAX=4 -> LOAD windows of exactly 4 transfers separated by FETCH windows, all 10 words written once, in order.
REQ-032 SHALL cover mid-burst reset: rst=1 for 1 cycle after 2nd transfer of a 4-word burst -> mem_we=0 and ld_ready=0 in reset cycle, grant_ld=0 next cycle, no third write before re-arbitration.
REQ-033 SHALL cover abandoned burst: in LOAD, ld_last=0, ld_valid dropped to 0 -> one LOAD cycle with mem_we=0 and ld_ready=0, FETCH next cycle.
